// File: rtl/pc_sequencer_pkg.sv
// Shared CPU definitions for the program-counter sequencer: PC width,
// fetch timeout default and the sequencer state encoding.
package pc_sequencer_pkg;

  localparam int PC_W                  = 32;
  localparam int FETCH_TIMEOUT_DEFAULT = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_HALT   = 3'd4,
    ST_ERROR  = 3'd5
  } state_t;

endpackage

// File: rtl/jumpALU.sv
// Branch/sequential target adder: target = inputPC + offset, modulo 2^32.
module jumpALU
  import pc_sequencer_pkg::*;
(
  input  logic [PC_W-1:0] inputPC,
  input  logic [PC_W-1:0] offset,
  output logic [PC_W-1:0] targetPC
);

  assign targetPC = inputPC + offset;

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: IDLE/FETCH/DECODE/EXEC control with fetch
// timeout detection and terminal HALT/ERROR states.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC      = 32'h0000_0000,
  parameter int              FETCH_TIMEOUT = FETCH_TIMEOUT_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run,
  input  logic            imem_ready,
  input  logic            is_branch,
  input  logic            branch_taken,
  input  logic            is_jump,
  input  logic            is_halt,
  input  logic [PC_W-1:0] offset,
  output logic [PC_W-1:0] pc,
  output logic            imem_req,
  output logic            pc_update,
  output logic            halted,
  output logic            stall_err
);

  localparam int CNT_W = $clog2(FETCH_TIMEOUT + 1);

  state_t            state;
  state_t            state_next;
  logic [CNT_W-1:0]  wait_cnt;
  logic [CNT_W-1:0]  wait_cnt_next;
  logic [CNT_W-1:0]  wait_cnt_inc;
  logic              dec_jump;
  logic              dec_taken;
  logic [PC_W-1:0]   dec_offset;
  logic [PC_W-1:0]   pc_inc;
  logic [PC_W-1:0]   alu_operand;
  logic [PC_W-1:0]   branch_target;
  logic [PC_W-1:0]   pc_next;

  assign wait_cnt_inc = wait_cnt + CNT_W'(1);
  assign pc_inc       = pc + PC_W'(1);

  // Next-state and wait-counter logic
  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    case (state)
      ST_IDLE: begin
        if (run) begin
          state_next    = ST_FETCH;
          wait_cnt_next = '0;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (imem_ready) begin
          state_next = ST_DECODE;
        end else if (wait_cnt_inc == CNT_W'(FETCH_TIMEOUT)) begin
          state_next = ST_ERROR;
        end else begin
          wait_cnt_next = wait_cnt_inc;
        end
      end
      ST_DECODE: begin
        if (is_halt) begin
          state_next = ST_HALT;
        end else begin
          state_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (run) begin
          state_next    = ST_FETCH;
          wait_cnt_next = '0;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_HALT:  state_next = ST_HALT;
      ST_ERROR: state_next = ST_ERROR;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Untaken branches and plain instructions feed zero, so one adder covers both
  always_comb begin
    if (dec_taken) begin
      alu_operand = dec_offset;
    end else begin
      alu_operand = '0;
    end
    if (dec_jump) begin
      pc_next = dec_offset;
    end else begin
      pc_next = branch_target;
    end
  end

  jumpALU u_jump_alu (
    .inputPC  (pc_inc),
    .offset   (alu_operand),
    .targetPC (branch_target)
  );

  // State, counter and registered status outputs (decoded from next state)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      wait_cnt  <= '0;
      imem_req  <= 1'b0;
      pc_update <= 1'b0;
      halted    <= 1'b0;
      stall_err <= 1'b0;
    end else begin
      state     <= state_next;
      wait_cnt  <= wait_cnt_next;
      imem_req  <= (state_next == ST_FETCH);
      pc_update <= (state_next == ST_EXEC);
      halted    <= (state_next == ST_HALT);
      stall_err <= (state_next == ST_ERROR);
    end
  end

  // Decode capture and PC update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc         <= RESET_PC;
      dec_jump   <= 1'b0;
      dec_taken  <= 1'b0;
      dec_offset <= '0;
    end else begin
      if (state == ST_DECODE) begin
        dec_jump   <= is_jump;
        dec_taken  <= is_branch & branch_taken;
        dec_offset <= offset;
      end
      if (state == ST_EXEC) begin
        pc <= pc_next;
      end
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_pc_sequencer;

  logic        clk;
  logic        rst_n;
  logic        run;
  logic        imem_ready;
  logic        is_branch;
  logic        branch_taken;
  logic        is_jump;
  logic        is_halt;
  logic [31:0] offset;
  logic [31:0] pc;
  logic        imem_req;
  logic        pc_update;
  logic        halted;
  logic        stall_err;

  int vectors = 0;
  int fails   = 0;
  int pulses  = 0;

  // Model: phase of the current instruction, expressed as a plain int
  // (0 idle, 1 fetch, 2 decode, 3 exec, 4 halt, 5 error).
  int          mphase;
  int          mwait;
  logic [31:0] mpc;
  logic        mj;
  logic        mbt;
  logic [31:0] moff;
  logic        stall_mode;

  pc_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .run          (run),
    .imem_ready   (imem_ready),
    .is_branch    (is_branch),
    .branch_taken (branch_taken),
    .is_jump      (is_jump),
    .is_halt      (is_halt),
    .offset       (offset),
    .pc           (pc),
    .imem_req     (imem_req),
    .pc_update    (pc_update),
    .halted       (halted),
    .stall_err    (stall_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endfunction

  function automatic void model_reset();
    mphase = 0;
    mwait  = 0;
    mpc    = 32'h0000_0000;
    mj     = 1'b0;
    mbt    = 1'b0;
    moff   = 32'h0000_0000;
  endfunction

  function automatic void model_step();
    if (!rst_n) return;
    case (mphase)
      0: if (run) begin mphase = 1; mwait = 0; end
      1: begin
        if (imem_ready) mphase = 2;
        else begin
          mwait++;
          if (mwait >= 16) mphase = 5;
        end
      end
      2: begin
        mj     = is_jump;
        mbt    = is_branch && branch_taken;
        moff   = offset;
        mphase = is_halt ? 4 : 3;
      end
      3: begin
        if (mj)       mpc = moff;
        else if (mbt) mpc = mpc + 32'd1 + moff;
        else          mpc = mpc + 32'd1;
        mphase = run ? 1 : 0;
        mwait  = 0;
      end
      default: ;
    endcase
  endfunction

  function automatic void check_all();
    chk("pc",        pc,                32'(mpc));
    chk("imem_req",  32'(imem_req),     32'(mphase == 1));
    chk("pc_update", 32'(pc_update),    32'(mphase == 3));
    chk("halted",    32'(halted),       32'(mphase == 4));
    chk("stall_err", 32'(stall_err),    32'(mphase == 5));
  endfunction

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
    if (pc_update) pulses++;
  endtask

  // Called at a negedge: assert reset mid-cycle, check asynchronous effect.
  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    chk("rst_async_pc", pc, 32'h0000_0000);
    @(negedge clk);
    rst_n  = 1'b1;
    pulses = 0;
  endtask

  task automatic set_flags(input logic j, input logic b, input logic t,
                           input logic h, input logic [31:0] off);
    is_jump      = j;
    is_branch    = b;
    branch_taken = t;
    is_halt      = h;
    offset       = off;
  endtask

  // One full instruction from the start of FETCH with imem_ready high.
  task automatic instr(input logic j, input logic b, input logic t,
                       input logic [31:0] off);
    set_flags(j, b, t, 1'b0, off);
    repeat (3) cyc();
  endtask

  initial begin
    rst_n      = 1'b0;
    run        = 1'b0;
    imem_ready = 1'b0;
    stall_mode = 1'b0;
    set_flags(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    model_reset();
    @(negedge clk);
    do_reset();

    // Sequential stepping from reset
    run        = 1'b1;
    imem_ready = 1'b1;
    repeat (4) cyc();
    chk("seq_pc1", pc, 32'h1);
    repeat (3) cyc();
    chk("seq_pc2", pc, 32'h2);
    repeat (3) cyc();
    chk("seq_pc3", pc, 32'h3);
    chk("seq_pulses", 32'(pulses), 32'd3);

    // Jump / branch arithmetic
    instr(1'b1, 1'b0, 1'b0, 32'h0000_000E);
    chk("jump_0e", pc, 32'h0E);
    instr(1'b0, 1'b1, 1'b1, 32'h0000_0001);
    chk("br_fwd", pc, 32'h10);
    instr(1'b1, 1'b0, 1'b0, 32'h0000_000E);
    instr(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF);
    chk("br_neg", pc, 32'h0E);
    instr(1'b0, 1'b1, 1'b0, 32'h0000_0005);
    chk("br_not_taken", pc, 32'h0F);
    instr(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF);
    chk("jump_max", pc, 32'hFFFF_FFFF);
    instr(1'b0, 1'b0, 1'b0, 32'h0000_0000);
    chk("wrap", pc, 32'h0);
    instr(1'b1, 1'b1, 1'b1, 32'h0000_0020);
    chk("jump_wins", pc, 32'h20);

    // Dropping run mid-instruction lets it finish, then idles
    run = 1'b0;
    instr(1'b0, 1'b0, 1'b0, 32'h0000_0000);
    chk("run_drop_pc", pc, 32'h21);
    repeat (2) cyc();
    chk("idle_no_req", 32'(imem_req), 32'd0);

    // Fetch timeout
    run = 1'b1;
    cyc();
    imem_ready = 1'b0;
    repeat (15) cyc();
    chk("stall_before", 32'(stall_err), 32'd0);
    cyc();
    chk("stall_err", 32'(stall_err), 32'd1);
    chk("stall_req", 32'(imem_req), 32'd0);
    imem_ready = 1'b1;
    repeat (3) cyc();
    chk("stall_pc", pc, 32'h21);
    do_reset();

    // Halt is terminal and freezes pc
    run = 1'b1;
    cyc();
    set_flags(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0077);
    repeat (2) cyc();
    chk("halted", 32'(halted), 32'd1);
    set_flags(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0077);
    for (int i = 0; i < 4; i++) begin
      run = i[0];
      cyc();
    end
    chk("halt_pc", pc, 32'h0);
    chk("halt_hold", 32'(halted), 32'd1);
    do_reset();

    // Reset mid-FETCH discards the instruction
    run = 1'b1;
    cyc();
    instr(1'b1, 1'b0, 1'b0, 32'h0000_0055);
    chk("pre_rst_pc", pc, 32'h55);
    do_reset();
    chk("rst_req", 32'(imem_req), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ((mphase >= 4 && $urandom_range(0, 3) == 0) || $urandom_range(0, 299) == 0) begin
        do_reset();
        stall_mode = ($urandom_range(0, 3) == 0);
      end
      run        = ($urandom_range(0, 7) != 0);
      imem_ready = stall_mode ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 3) != 0);
      is_jump      = ($urandom_range(0, 5) == 0);
      is_branch    = ($urandom_range(0, 2) == 0);
      branch_taken = $urandom_range(0, 1) == 1;
      is_halt      = ($urandom_range(0, 39) == 0);
      case ($urandom_range(0, 2))
        0:       offset = 32'($urandom_range(0, 15));
        1:       offset = 32'h0 - 32'($urandom_range(1, 15));
        default: offset = $urandom;
      endcase
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000: PC value loaded by reset.
REQ-002 Parameter FETCH_TIMEOUT, default 16: maximum FETCH cycles without imem_ready before error.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 run  input  1  level enable; sampled in IDLE and at EXEC exit.
REQ-006 imem_ready  input  1  instruction memory has returned the word at pc; honoured only in FETCH.
REQ-007 is_branch, branch_taken, is_jump, is_halt  input  1 each  decode flags; sampled in DECODE only.
REQ-008 offset  input  32  two's-complement branch offset or absolute jump target; sampled in DECODE only.
REQ-009 pc  output  32  current program counter (word address).
REQ-010 imem_req  output  1  fetch request; high exactly while in FETCH.
REQ-011 pc_update  output  1  one-cycle pulse, high in EXEC.
REQ-012 halted  output  1  high while in HALT.
REQ-013 stall_err  output  1  high while in ERROR.

Function
REQ-014 The sequencer SHALL use exactly six states: IDLE, FETCH, DECODE, EXEC, HALT, ERROR.
REQ-015 IDLE: run=1 -> FETCH next cycle; run=0 -> remain IDLE.
REQ-016 FETCH: imem_req=1, pc held; imem_ready=1 -> DECODE; wait counter increments each FETCH cycle without ready; counter reaching FETCH_TIMEOUT -> ERROR.
REQ-017 The wait counter SHALL clear on entry to FETCH, so each fetch gets the full FETCH_TIMEOUT budget.
REQ-018 DECODE: flags and offset registered; is_halt=1 -> HALT; else -> EXEC.
REQ-019 EXEC: pc loads the next PC at the end of the cycle; pc_update=1; then run=1 -> FETCH, run=0 -> IDLE.
REQ-020 Next-PC selection, priority high to low: is_jump -> offset (absolute); is_branch & branch_taken -> pc+1+offset; otherwise -> pc+1.
REQ-021 pc+1+offset SHALL be produced by one adder with operands (pc+1, offset) or (pc+1, 0); all arithmetic is 32-bit modulo 2^32 with no overflow flag.
REQ-022 Wrap-around: pc=32'hFFFFFFFF sequential -> 32'h00000000.
REQ-023 Negative offset: pc=32'h0E, taken branch, offset=32'hFFFFFFFF -> pc=32'h0E.
REQ-024 Latency: with imem_ready in the first FETCH cycle, one instruction takes 3 cycles (FETCH, DECODE, EXEC), and pc changes once per instruction.
REQ-025 Deasserting run mid-instruction SHALL NOT abort it; the current instruction completes, then the sequencer enters IDLE.
REQ-026 Decode inputs and imem_ready outside their sampling state SHALL have no effect.
REQ-027 HALT and ERROR are terminal; only rst_n exits them; pc is frozen in both.

Reset
REQ-028 rst_n low SHALL asynchronously force state=IDLE, pc=RESET_PC, wait counter=0, imem_req=0, pc_update=0, halted=0, stall_err=0.
REQ-029 Reset asserted in any state, including mid-FETCH or EXEC, SHALL discard the instruction in progress with no pc update.
REQ-030 After rst_n deasserts, the first FETCH SHALL occur only after run is sampled high in IDLE.

Structure
REQ-031 State encodings, the 32-bit PC width constant and the FETCH_TIMEOUT default belong in the shared CPU package.
REQ-032 The branch adder SHALL be the existing jumpALU module, instantiated once (inputPC=pc+1, offset=selected operand); there are no other sub-modules.

Verification
REQ-033 Reset with RESET_PC=0, run=1, imem_ready always 1, no flags set -> pc steps 0,1,2,3, each value held 3 cycles, with one pc_update pulse per step.
REQ-034 Jump with offset=32'h0E, then taken branch with offset=1 -> pc=32'h10; repeat from 32'h0E with offset=32'hFFFFFFFF -> pc=32'h0E; not taken from 32'h0E -> 32'h0F.
REQ-035 Jump to 32'hFFFFFFFF, then sequential instruction -> pc=32'h00000000; is_jump and is_branch both set -> jump wins.
REQ-036 imem_ready held 0 for 16 FETCH cycles -> stall_err=1 and imem_req=0 from the next cycle; pc unchanged until rst_n.
REQ-037 is_halt in DECODE -> halted=1 and pc frozen; run toggling has no effect; rst_n low mid-FETCH -> pc=RESET_PC and IDLE immediately, asynchronously.
